// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory handshake, redirect sources and IF/ID-facing outputs.
// The master modport is the PC sequencer; the slave modport is the surrounding pipeline and memory.
interface pc_fetch_ctrl_if #(
  parameter int DW = 32
);
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          stall_id;
  logic          exe_br_taken;
  logic [DW-1:0] exe_br_target;
  logic          exe_jalr;
  logic [DW-1:0] exe_jalr_target;
  logic          id_jal;
  logic [DW-1:0] id_jal_target;
  logic          ifu_valid;
  logic [31:0]   ifu_instr;
  logic [DW-1:0] ifu_pc;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic [15:0]   redirect_cnt;

  modport master (
    output if_req, if_addr, ifu_valid, ifu_instr, ifu_pc,
           flush_if_id, flush_id_ex, redirect_cnt,
    input  if_ack, if_rdata, stall_id, exe_br_taken, exe_br_target,
           exe_jalr, exe_jalr_target, id_jal, id_jal_target
  );

  modport slave (
    input  if_req, if_addr, ifu_valid, ifu_instr, ifu_pc,
           flush_if_id, flush_id_ex, redirect_cnt,
    output if_ack, if_rdata, stall_id, exe_br_taken, exe_br_target,
           exe_jalr, exe_jalr_target, id_jal, id_jal_target
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: owns the fetch pointer, drives the imem request, arbitrates redirects,
// raises flushes and skids one instruction while ID stalls. Stale requests are drained, never retracted.
module pc_fetch_ctrl #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_ctrl_if.master  bus
);
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fptr_q, fptr_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [DW-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]   buf_instr_q, buf_instr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          if_req_q, if_req_d;
  logic          jal_ok, exe_redir, redir;
  logic [DW-1:0] tgt;

  // id_jal is only meaningful when ID actually holds the JAL this cycle.
  always_comb begin
    jal_ok    = bus.id_jal & ~bus.stall_id;
    exe_redir = bus.exe_br_taken | bus.exe_jalr;
    redir     = exe_redir | jal_ok;
    if (bus.exe_br_taken)  tgt = bus.exe_br_target;
    else if (bus.exe_jalr) tgt = bus.exe_jalr_target;
    else                   tgt = bus.id_jal_target;
  end

  assign bus.flush_id_ex  = exe_redir & ~rst;
  assign bus.flush_if_id  = redir & ~rst;
  assign bus.if_req       = if_req_q;
  assign bus.if_addr      = fptr_q;
  assign bus.redirect_cnt = cnt_q;

  always_comb begin
    state_d       = state_q;
    fptr_d        = fptr_q;
    tgt_d         = tgt_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    bus.ifu_valid = 1'b0;
    bus.ifu_instr = bus.if_rdata;
    bus.ifu_pc    = fptr_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.if_ack) begin
          if (redir) begin
            fptr_d = tgt;
          end else begin
            bus.ifu_valid = 1'b1;
            fptr_d        = fptr_q + DW'(4);
            if (bus.stall_id) begin
              buf_instr_d = bus.if_rdata;
              buf_pc_d    = fptr_q;
              state_d     = HOLD;
            end
          end
        end else if (redir) begin
          tgt_d   = tgt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Later redirects come from older instructions, so the newest target wins.
        if (bus.if_ack) begin
          fptr_d  = redir ? tgt : tgt_q;
          state_d = FETCH;
        end else if (redir) begin
          tgt_d = tgt;
        end
      end
      HOLD: begin
        bus.ifu_valid = 1'b1;
        bus.ifu_instr = buf_instr_q;
        bus.ifu_pc    = buf_pc_q;
        if (redir) begin
          fptr_d  = tgt;
          state_d = FETCH;
        end else if (!bus.stall_id) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    cnt_d    = (redir && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    if_req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      fptr_q      <= RESET_PC;
      tgt_q       <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      cnt_q       <= '0;
      if_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fptr_q      <= fptr_d;
      tgt_q       <= tgt_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      cnt_q       <= cnt_d;
      if_req_q    <= if_req_d;
    end
  end
endmodule
